regfile_dbg_arbiter: RTL and testbench
======================================

Name: regfile_dbg_arbiter

Overview:
- Shares register-file port A between the CPU core (priority requester) and the debug/monitor host. Debug reads/writes are squeezed into idle port-A cycles; a bounded-starvation stall guarantees forward progress.
- Optionally sequences a full register dump for the monitor.
- Sits between the decoder/core and registerFile's port-A control inputs; port B is untouched.

Parameters:
- STARVE_LIMIT, 8: consecutive core-busy cycles with a debug request pending before the core is stalled for one grant (range 1..255).
- DUMP_LAST, 15: last register index visited by a dump (0..15).

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- CORE_REGA_EN / CORE_REGA_WEN  in  1 / 1  core port-A enable / write enable
- CORE_REGA_BYTE_EN  in  2  core byte enables
- CORE_ARGA_X  in  4  core register index
- CORE_REGA_ADDRX  in  2  core address select
- CORE_REGA_DINX  in  2  core data select
- CORE_REGA_BYTEX  in  1  core byte select
- CORE_STALL  out  1  core must hold state and not issue this cycle
- DBG_REQ  in  1  debug request, held until DBG_ACK
- DBG_WR  in  1  1=write, 0=read
- DBG_DUMP  in  1  with DBG_REQ: dump registers 0..DUMP_LAST
- DBG_ADDR  in  4  debug register index
- DBG_WDATA  in  16  debug write data
- DBG_ACK  out  1  one-cycle request completion pulse
- DBG_BUSY  out  1  debug transaction in progress
- DBG_RVALID  out  1  one-cycle read-data pulse
- DBG_RADDR  out  4  index of DBG_RDATA
- DBG_RDATA  out  16  read data
- REGA_DOUT  in  16  registerFile port-A output
- REGA_EN / REGA_WEN  out  1 / 1  to registerFile
- REGA_BYTE_EN  out  2  to registerFile
- ARGA_X  out  4  to registerFile
- REGA_ADDRX  out  2  to registerFile
- REGA_DINX  out  2  to registerFile
- REGA_BYTEX  out  1  to registerFile
- DIN_OVR  out  1  DIN mux selects DIN_OVR_DATA
- DIN_OVR_DATA  out  16  debug write data onto DIN

Behaviour:
- RESET low, asynchronous:
  - State returns to IDLE; starve counter and dump index are cleared.
  - All registered outputs go to 0.
  - REGA_EN, REGA_WEN, REGA_BYTE_EN and DIN_OVR are forced to 0 for as long as RESET is low.
  - An aborted debug transaction produces no ACK.
- Pass-through: in every cycle without a debug grant, all REGA_* outputs equal the corresponding CORE_* inputs combinationally. DIN_OVR=0.
- Grant conditions: a debug access is granted in cycle G when a debug operation is pending and either:
  - CORE_REGA_EN=0, or
  - CORE_STALL=1.
  - If the core also requests in the same cycle without a stall, the core wins.
- Grant cycle drives:
  - REGA_EN=1, REGA_WEN=DBG_WR, REGA_BYTE_EN=2'b11.
  - REGA_ADDRX=REGA_ADDRX_ARGX (2'b00, ARGA_X select), ARGA_X=latched address.
  - Write: REGA_DINX=REGA_DINX_DIN, DIN_OVR=1, DIN_OVR_DATA=latched data.
- Request latching: DBG_ADDR, DBG_WR, DBG_WDATA and DBG_DUMP are latched on the first cycle DBG_REQ=1 in IDLE. DBG_BUSY rises the next cycle.
- Starve counter:
  - Increments on each cycle with debug pending and CORE_REGA_EN=1 and no grant.
  - On reaching STARVE_LIMIT, CORE_STALL is registered high for exactly one cycle; the grant occurs in that cycle.
  - Clears on every grant.
- States:
  - IDLE: on DBG_REQ, go to PEND.
  - PEND: on grant, go to RD1 (read) or WR1 (write).
  - WR1: DBG_ACK=1, then IDLE.
  - RD1 (G+1): REGA_DOUT is valid and is captured.
  - RD2 (G+2): DBG_RVALID=1 and DBG_RDATA/DBG_RADDR are valid. For a single read, DBG_ACK=1 in the same cycle and go to IDLE.
- Read latency: grant to DBG_RVALID is 2 cycles. Write: grant to DBG_ACK is 1 cycle.
- Dump:
  - Index starts at 0.
  - Each register is read as a single read, returning to PEND between reads.
  - DBG_RVALID pulses once per register with DBG_RADDR=index.
  - DBG_ACK pulses only with the DBG_RVALID of index DUMP_LAST.
  - A dump with DBG_WR=1 is treated as a dump (read-only).
- Core traffic in RD1/RD2 is passed through. REGA_DOUT sampled in RD1 belongs to the debug access because the core did not use port A in G.
- DBG_REQ must drop the cycle after DBG_ACK. A re-raise is a new request, accepted at the earliest one cycle after returning to IDLE.

Optional Feature:
- REGARB_DUMP_EN defined: the dump sequencer is present, as described above.
- REGARB_DUMP_EN undefined:
  - DBG_DUMP is ignored; the request executes as a single read/write of DBG_ADDR.
  - The dump index register is absent.

Test Plan:
- Core idle, debug read ADDR=4 with R4=16'h1234: grant at G, DBG_RVALID/DBG_RDATA=16'h1234, DBG_RADDR=4 and DBG_ACK at G+2.
- Debug write ADDR=7, WDATA=16'hBEEF while core idle: at G REGA_WEN=1, ARGA_X=7, DIN_OVR=1; ACK at G+1; a following read returns 16'hBEEF.
- Core holds CORE_REGA_EN=1 continuously and debug read pending: no grant for 8 cycles, CORE_STALL=1 on cycle 9 with grant; the core's REGA_* are not passed that cycle.
- Debug request and core request arrive in the same cycle: core controls pass through, no grant, starve counter=1; the core drops its request the next cycle and debug is granted.
- Dump with REGARB_DUMP_EN, registers preloaded Rn=16'h0100+n: 16 RVALID pulses with RADDR 0..15 and data 16'h0100..16'h010F, a single ACK with RADDR=15.
- Assert RESET low in RD1 of a read: outputs 0 immediately; no RVALID/ACK; after release, IDLE and a new read completes normally.

Source files
------------

// File: rtl/regfile_dbg_arbiter.sv
// regfile_dbg_arbiter
// Shares registerFile port A between the CPU core, which has priority, and the
// debug/monitor host. Debug accesses use idle port-A cycles. If the core keeps
// the port busy for STARVE_LIMIT cycles while debug waits, the core is stalled
// for one cycle so that debug can take that cycle.
// Read:  grant G -> capture REGA_DOUT at G+1 -> DBG_RVALID/DBG_ACK at G+2.
// Write: grant G -> DBG_ACK at G+1.
// Optional feature, enabled with the macro REGARB_DUMP_EN: a dump sequencer
// that reads registers 0..DUMP_LAST for the monitor. In the default build
// DBG_DUMP is ignored and every request is a single access to DBG_ADDR.
module regfile_dbg_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int DUMP_LAST    = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CORE_REGA_EN,
  input  logic        CORE_REGA_WEN,
  input  logic [1:0]  CORE_REGA_BYTE_EN,
  input  logic [3:0]  CORE_ARGA_X,
  input  logic [1:0]  CORE_REGA_ADDRX,
  input  logic [1:0]  CORE_REGA_DINX,
  input  logic        CORE_REGA_BYTEX,
  output logic        CORE_STALL,
  input  logic        DBG_REQ,
  input  logic        DBG_WR,
  input  logic        DBG_DUMP,
  input  logic [3:0]  DBG_ADDR,
  input  logic [15:0] DBG_WDATA,
  output logic        DBG_ACK,
  output logic        DBG_BUSY,
  output logic        DBG_RVALID,
  output logic [3:0]  DBG_RADDR,
  output logic [15:0] DBG_RDATA,
  input  logic [15:0] REGA_DOUT,
  output logic        REGA_EN,
  output logic        REGA_WEN,
  output logic [1:0]  REGA_BYTE_EN,
  output logic [3:0]  ARGA_X,
  output logic [1:0]  REGA_ADDRX,
  output logic [1:0]  REGA_DINX,
  output logic        REGA_BYTEX,
  output logic        DIN_OVR,
  output logic [15:0] DIN_OVR_DATA
);

  // FSM encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PEND = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_RD2  = 3'd3;
  localparam logic [2:0] S_WR1  = 3'd4;

  // Port-A mux selects used by a debug grant
  localparam logic [1:0] REGA_ADDRX_ARGX = 2'b00;
  localparam logic [1:0] REGA_DINX_DIN   = 2'b00;

  // Counter value at which the next starved cycle raises the stall
  localparam logic [7:0] STARVE_LAST   = 8'(STARVE_LIMIT - 1);
  localparam logic [3:0] DUMP_LAST_IDX = 4'(DUMP_LAST);

  logic [2:0]  state_q;
  logic [3:0]  addr_q;
  logic        wr_q;
  logic [15:0] wdata_q;
  logic [7:0]  starve_q;
  logic        stall_q;
  logic        ack_q;
  logic        hold_q;
  logic        vld_p2;
  logic [3:0]  raddr_p2;
  logic [15:0] rdata_p2;

  logic        pend;
  logic        grant;
  logic        stall_set;
  logic [3:0]  acc_addr;
  logic        dump_more;

`ifdef REGARB_DUMP_EN
  logic        dump_q;
  logic [3:0]  idx_q;

  // During a dump the sequencer index replaces the requested address
  assign acc_addr  = dump_q ? idx_q : addr_q;
  assign dump_more = dump_q && (idx_q != DUMP_LAST_IDX);
`else
  logic unused_dbg_dump;

  assign unused_dbg_dump = DBG_DUMP;
  assign acc_addr        = addr_q;
  assign dump_more       = 1'b0;
`endif

  // Debug takes port A only when it is free or when the core has been stalled
  assign pend      = (state_q == S_PEND);
  assign grant     = pend && (!CORE_REGA_EN || stall_q);
  assign stall_set = pend && CORE_REGA_EN && !grant && (starve_q == STARVE_LAST);

  // Counts how long a pending debug access has been blocked by the core
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      starve_q <= 8'd0;
      stall_q  <= 1'b0;
    end else begin
      stall_q <= stall_set;
      if (grant) begin
        starve_q <= 8'd0;
      end else if (pend && CORE_REGA_EN && (starve_q != 8'hFF)) begin
        starve_q <= starve_q + 8'd1;
      end
    end
  end

  // Request latching and transaction sequencing
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      addr_q  <= 4'd0;
      wr_q    <= 1'b0;
      wdata_q <= 16'd0;
`ifdef REGARB_DUMP_EN
      dump_q  <= 1'b0;
      idx_q   <= 4'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // The cycle right after an ACK still shows the old request, so it is ignored
          if (DBG_REQ && !hold_q) begin
            addr_q  <= DBG_ADDR;
            wdata_q <= DBG_WDATA;
            state_q <= S_PEND;
`ifdef REGARB_DUMP_EN
            wr_q    <= DBG_WR && !DBG_DUMP;
            dump_q  <= DBG_DUMP;
            idx_q   <= 4'd0;
`else
            wr_q    <= DBG_WR;
`endif
          end
        end
        S_PEND: begin
          if (grant) begin
            state_q <= wr_q ? S_WR1 : S_RD1;
          end
        end
        S_WR1: begin
          state_q <= S_IDLE;
        end
        S_RD1: begin
          state_q <= S_RD2;
        end
        S_RD2: begin
          if (dump_more) begin
`ifdef REGARB_DUMP_EN
            idx_q   <= idx_q + 4'd1;
`endif
            state_q <= S_PEND;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Read-data capture and completion pulses
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      vld_p2   <= 1'b0;
      raddr_p2 <= 4'd0;
      rdata_p2 <= 16'd0;
      ack_q    <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      // ---- RD1 -> RD2: REGA_DOUT holds the word addressed in the grant cycle
      vld_p2 <= (state_q == S_RD1);
      if (state_q == S_RD1) begin
        raddr_p2 <= acc_addr;
        rdata_p2 <= REGA_DOUT;
      end
      // A write acknowledges one cycle after its grant; a read or the last
      // dump read acknowledges together with its read data
      ack_q  <= (grant && wr_q) || ((state_q == S_RD1) && !dump_more);
      hold_q <= ack_q;
    end
  end

  // Port-A mux: core pass-through unless debug holds the grant
  always_comb begin
    REGA_EN      = CORE_REGA_EN;
    REGA_WEN     = CORE_REGA_WEN;
    REGA_BYTE_EN = CORE_REGA_BYTE_EN;
    ARGA_X       = CORE_ARGA_X;
    REGA_ADDRX   = CORE_REGA_ADDRX;
    REGA_DINX    = CORE_REGA_DINX;
    REGA_BYTEX   = CORE_REGA_BYTEX;
    DIN_OVR      = 1'b0;
    if (grant) begin
      REGA_EN      = 1'b1;
      REGA_WEN     = wr_q;
      REGA_BYTE_EN = 2'b11;
      ARGA_X       = acc_addr;
      REGA_ADDRX   = REGA_ADDRX_ARGX;
      REGA_DINX    = REGA_DINX_DIN;
      REGA_BYTEX   = 1'b0;
      DIN_OVR      = wr_q;
    end
    // Reset must keep the register file from being touched at all
    if (!RESET) begin
      REGA_EN      = 1'b0;
      REGA_WEN     = 1'b0;
      REGA_BYTE_EN = 2'b00;
      DIN_OVR      = 1'b0;
    end
  end

  assign CORE_STALL   = stall_q;
  assign DBG_ACK      = ack_q;
  assign DBG_BUSY     = (state_q != S_IDLE);
  assign DBG_RVALID   = vld_p2;
  assign DBG_RADDR    = raddr_p2;
  assign DBG_RDATA    = rdata_p2;
  assign DIN_OVR_DATA = wdata_q;

endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// Bench for regfile_dbg_arbiter: a behavioural register file sits on port A,
// expected debug read results are queued when a grant is observed and are
// consumed when DBG_RVALID appears.
module tb_regfile_dbg_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CORE_REGA_EN, CORE_REGA_WEN, CORE_REGA_BYTEX;
  logic [1:0]  CORE_REGA_BYTE_EN, CORE_REGA_ADDRX, CORE_REGA_DINX;
  logic [3:0]  CORE_ARGA_X;
  logic        CORE_STALL;
  logic        DBG_REQ, DBG_WR, DBG_DUMP;
  logic [3:0]  DBG_ADDR;
  logic [15:0] DBG_WDATA;
  logic        DBG_ACK, DBG_BUSY, DBG_RVALID;
  logic [3:0]  DBG_RADDR;
  logic [15:0] DBG_RDATA;
  logic [15:0] REGA_DOUT;
  logic        REGA_EN, REGA_WEN, REGA_BYTEX, DIN_OVR;
  logic [1:0]  REGA_BYTE_EN, REGA_ADDRX, REGA_DINX;
  logic [3:0]  ARGA_X;
  logic [15:0] DIN_OVR_DATA;

  always #5 CLK = ~CLK;

  regfile_dbg_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .CORE_REGA_EN(CORE_REGA_EN), .CORE_REGA_WEN(CORE_REGA_WEN),
    .CORE_REGA_BYTE_EN(CORE_REGA_BYTE_EN), .CORE_ARGA_X(CORE_ARGA_X),
    .CORE_REGA_ADDRX(CORE_REGA_ADDRX), .CORE_REGA_DINX(CORE_REGA_DINX),
    .CORE_REGA_BYTEX(CORE_REGA_BYTEX), .CORE_STALL(CORE_STALL),
    .DBG_REQ(DBG_REQ), .DBG_WR(DBG_WR), .DBG_DUMP(DBG_DUMP),
    .DBG_ADDR(DBG_ADDR), .DBG_WDATA(DBG_WDATA),
    .DBG_ACK(DBG_ACK), .DBG_BUSY(DBG_BUSY), .DBG_RVALID(DBG_RVALID),
    .DBG_RADDR(DBG_RADDR), .DBG_RDATA(DBG_RDATA),
    .REGA_DOUT(REGA_DOUT), .REGA_EN(REGA_EN), .REGA_WEN(REGA_WEN),
    .REGA_BYTE_EN(REGA_BYTE_EN), .ARGA_X(ARGA_X), .REGA_ADDRX(REGA_ADDRX),
    .REGA_DINX(REGA_DINX), .REGA_BYTEX(REGA_BYTEX),
    .DIN_OVR(DIN_OVR), .DIN_OVR_DATA(DIN_OVR_DATA)
  );

  // Behavioural register file: synchronous read, DIN taken from the override
  logic [15:0] rf [16];
  logic [15:0] rf_dout;
  logic        preload;

  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0100 + 16'(i);
      rf[4]   <= 16'h1234;
      rf_dout <= 16'h0000;
    end else if (REGA_EN) begin
      if (REGA_WEN) rf[ARGA_X] <= DIN_OVR ? DIN_OVR_DATA : 16'h0000;
      else          rf_dout    <= rf[ARGA_X];
    end
  end
  assign REGA_DOUT = rf_dout;

  // Bench-side expectation of register contents
  logic [15:0] exp_mem [16];

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_chk  = 0;
  int n_fail = 0;
  int ack_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every read-data pulse must match the oldest expectation
  always @(negedge CLK) begin
    if (RESET) begin
      if (DBG_RVALID) begin
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("raddr", 32'(DBG_RADDR), 32'(mon_e.a));
          chk("rdata", 32'(DBG_RDATA), 32'(mon_e.d));
        end
      end
      if (DBG_ACK) ack_cnt++;
    end
  end

  task automatic drive_edge();
    @(posedge CLK);
    #1;
  endtask

  // Single debug access with the core idle; starts and ends at a drive point
  task automatic dbg_op(input logic [3:0] addr, input logic wr, input logic [15:0] wd,
                        input logic dump);
    CORE_REGA_EN = 1'b0;
    DBG_REQ = 1'b1; DBG_ADDR = addr; DBG_WR = wr; DBG_WDATA = wd; DBG_DUMP = dump;
    @(negedge CLK);
    chk("busy_at_req", 32'(DBG_BUSY), 32'd0);
    drive_edge();
    @(negedge CLK);
    chk("gnt_en",     32'(REGA_EN),      32'd1);
    chk("gnt_wen",    32'(REGA_WEN),     32'(wr));
    chk("gnt_argx",   32'(ARGA_X),       32'(addr));
    chk("gnt_addrx",  32'(REGA_ADDRX),   32'd0);
    chk("gnt_byteen", 32'(REGA_BYTE_EN), 32'd3);
    chk("gnt_dinovr", 32'(DIN_OVR),      32'(wr));
    chk("gnt_busy",   32'(DBG_BUSY),     32'd1);
    if (wr) begin
      chk("gnt_dinx",  32'(REGA_DINX),    32'd0);
      chk("gnt_wdata", 32'(DIN_OVR_DATA), 32'(wd));
      exp_mem[addr] = wd;
      @(negedge CLK);
      chk("wr_ack",    32'(DBG_ACK),    32'd1);
      chk("wr_rvalid", 32'(DBG_RVALID), 32'd0);
    end else begin
      exp_q.push_back('{a: addr, d: exp_mem[addr]});
      @(negedge CLK);
      chk("rd1_ack",    32'(DBG_ACK),    32'd0);
      chk("rd1_rvalid", 32'(DBG_RVALID), 32'd0);
      @(negedge CLK);
      chk("rd2_rvalid", 32'(DBG_RVALID), 32'd1);
      chk("rd2_ack",    32'(DBG_ACK),    32'd1);
    end
    drive_edge();
    DBG_REQ = 1'b0; DBG_DUMP = 1'b0;
    @(negedge CLK);
    chk("busy_after", 32'(DBG_BUSY), 32'd0);
    drive_edge();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_start;
    int waited;
    RESET = 1'b0; preload = 1'b1;
    CORE_REGA_EN = 1'b1; CORE_REGA_WEN = 1'b0; CORE_REGA_BYTE_EN = 2'b11;
    CORE_ARGA_X = 4'd0; CORE_REGA_ADDRX = 2'b00; CORE_REGA_DINX = 2'b00;
    CORE_REGA_BYTEX = 1'b0;
    DBG_REQ = 1'b0; DBG_WR = 1'b0; DBG_DUMP = 1'b0; DBG_ADDR = 4'd0; DBG_WDATA = 16'd0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0100 + 16'(i);
    exp_mem[4] = 16'h1234;

    // Reset state
    #2;
    chk("rst_rega_en", 32'(REGA_EN),    32'd0);
    chk("rst_ack",     32'(DBG_ACK),    32'd0);
    chk("rst_rvalid",  32'(DBG_RVALID), 32'd0);
    chk("rst_rdata",   32'(DBG_RDATA),  32'd0);
    chk("rst_stall",   32'(CORE_STALL), 32'd0);
    chk("rst_busy",    32'(DBG_BUSY),   32'd0);
    CORE_REGA_EN = 1'b0;
    repeat (3) drive_edge();
    RESET = 1'b1; preload = 1'b0;
    drive_edge();

    // Pass-through with no debug activity
    CORE_REGA_EN = 1'b1; CORE_ARGA_X = 4'd11; CORE_REGA_ADDRX = 2'b10; CORE_REGA_DINX = 2'b01;
    CORE_REGA_BYTEX = 1'b1; CORE_REGA_BYTE_EN = 2'b10;
    #1;
    chk("pass_argx",   32'(ARGA_X),       32'd11);
    chk("pass_addrx",  32'(REGA_ADDRX),   32'd2);
    chk("pass_dinx",   32'(REGA_DINX),    32'd1);
    chk("pass_bytex",  32'(REGA_BYTEX),   32'd1);
    chk("pass_byteen", 32'(REGA_BYTE_EN), 32'd2);
    CORE_REGA_EN = 1'b0;
    drive_edge();

    // Read of R4 with the core idle
    dbg_op(4'd4, 1'b0, 16'h0000, 1'b0);
    // Write R7 then read it back
    dbg_op(4'd7, 1'b1, 16'hBEEF, 1'b0);
    dbg_op(4'd7, 1'b0, 16'h0000, 1'b0);

    // Core holds port A continuously: stall on the ninth pending cycle
    CORE_REGA_EN = 1'b1; CORE_REGA_WEN = 1'b0; CORE_ARGA_X = 4'd2;
    CORE_REGA_ADDRX = 2'b01; CORE_REGA_BYTE_EN = 2'b01;
    DBG_REQ = 1'b1; DBG_ADDR = 4'd9; DBG_WR = 1'b0;
    @(negedge CLK);
    chk("starve_c0_stall", 32'(CORE_STALL), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      drive_edge();
      @(negedge CLK);
      chk("starve_stall", 32'(CORE_STALL), 32'd0);
      chk("starve_argx",  32'(ARGA_X),     32'd2);
    end
    drive_edge();
    @(negedge CLK);
    chk("stall_high",   32'(CORE_STALL),   32'd1);
    chk("stall_argx",   32'(ARGA_X),       32'd9);
    chk("stall_addrx",  32'(REGA_ADDRX),   32'd0);
    chk("stall_byteen", 32'(REGA_BYTE_EN), 32'd3);
    exp_q.push_back('{a: 4'd9, d: exp_mem[9]});
    drive_edge();
    @(negedge CLK);
    chk("stall_once",   32'(CORE_STALL), 32'd0);
    chk("rd1_pass",     32'(ARGA_X),     32'd2);
    @(negedge CLK);
    chk("starve_ack",   32'(DBG_ACK),    32'd1);
    drive_edge();
    DBG_REQ = 1'b0; CORE_REGA_EN = 1'b0; CORE_REGA_ADDRX = 2'b00;
    @(negedge CLK);
    drive_edge();

    // Debug and core request together: core wins until it lets go
    CORE_REGA_EN = 1'b1; CORE_ARGA_X = 4'd1;
    DBG_REQ = 1'b1; DBG_ADDR = 4'd3; DBG_WR = 1'b0;
    @(negedge CLK);
    chk("coll_c0_argx", 32'(ARGA_X), 32'd1);
    drive_edge();
    @(negedge CLK);
    chk("coll_c1_argx",  32'(ARGA_X),     32'd1);
    chk("coll_c1_stall", 32'(CORE_STALL), 32'd0);
    drive_edge();
    CORE_REGA_EN = 1'b0;
    @(negedge CLK);
    chk("coll_gnt_en",   32'(REGA_EN),    32'd1);
    chk("coll_gnt_argx", 32'(ARGA_X),     32'd3);
    exp_q.push_back('{a: 4'd3, d: exp_mem[3]});
    @(negedge CLK);
    @(negedge CLK);
    chk("coll_ack", 32'(DBG_ACK), 32'd1);
    drive_edge();
    DBG_REQ = 1'b0;
    @(negedge CLK);
    drive_edge();

`ifdef REGARB_DUMP_EN
    // Dump with DBG_WR set must still only read
    for (int i = 0; i < 16; i++) exp_q.push_back('{a: 4'(i), d: exp_mem[i]});
    ack_start = ack_cnt;
    CORE_REGA_EN = 1'b0;
    DBG_REQ = 1'b1; DBG_DUMP = 1'b1; DBG_WR = 1'b1; DBG_ADDR = 4'd9; DBG_WDATA = 16'hDEAD;
    waited = 0;
    do begin
      @(negedge CLK);
      waited++;
    end while (!DBG_ACK && waited < 200);
    chk("dump_ack_seen",  32'(DBG_ACK),      32'd1);
    chk("dump_ack_raddr", 32'(DBG_RADDR),    32'd15);
    chk("dump_all_read",  32'(exp_q.size()), 32'd0);
    drive_edge();
    DBG_REQ = 1'b0; DBG_DUMP = 1'b0; DBG_WR = 1'b0;
    @(negedge CLK);
    chk("dump_one_ack", 32'(ack_cnt - ack_start), 32'd1);
    drive_edge();
    dbg_op(4'd9, 1'b0, 16'h0000, 1'b0);
`else
    // DBG_DUMP is ignored: a single read of DBG_ADDR
    ack_start = ack_cnt;
    waited = 0;
    dbg_op(4'd5, 1'b0, 16'h0000, 1'b1);
    chk("nodump_one_ack", 32'(ack_cnt - ack_start + waited), 32'd1);
`endif

    // Reset while a read is in RD1
    CORE_REGA_EN = 1'b0;
    DBG_REQ = 1'b1; DBG_ADDR = 4'd6; DBG_WR = 1'b0;
    @(negedge CLK);
    drive_edge();
    @(negedge CLK);
    chk("rstrd_gnt", 32'(REGA_EN), 32'd1);
    drive_edge();
    RESET = 1'b0; CORE_REGA_EN = 1'b1; DBG_REQ = 1'b0;
    #1;
    chk("rstrd_en",     32'(REGA_EN),      32'd0);
    chk("rstrd_wen",    32'(REGA_WEN),     32'd0);
    chk("rstrd_byteen", 32'(REGA_BYTE_EN), 32'd0);
    chk("rstrd_dinovr", 32'(DIN_OVR),      32'd0);
    chk("rstrd_busy",   32'(DBG_BUSY),     32'd0);
    chk("rstrd_rvalid", 32'(DBG_RVALID),   32'd0);
    chk("rstrd_ack",    32'(DBG_ACK),      32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rstrd_hold_rvalid", 32'(DBG_RVALID), 32'd0);
      chk("rstrd_hold_ack",    32'(DBG_ACK),    32'd0);
    end
    drive_edge();
    RESET = 1'b1; CORE_REGA_EN = 1'b0;
    ack_start = ack_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("post_rst_busy", 32'(DBG_BUSY), 32'd0);
    end
    chk("post_rst_no_ack", 32'(ack_cnt - ack_start), 32'd0);
    drive_edge();
    dbg_op(4'd6, 1'b0, 16'h0000, 1'b0);
    drive_edge();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
